// File: rtl/audio_adc_receiver.sv
// Serial audio ADC receiver: oversamples BCLK/ADCLRC/ADCDAT in the sys_clk domain
// and deserialises 24-bit left/right words, emitting complete stereo frames.
module audio_adc_receiver #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  bclk,
  input  logic                  adclrc,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] data_left,
  output logic [DATA_WIDTH-1:0] data_right,
  output logic                  sample_valid,
  output logic                  frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_IDLE  = CNT_W'(DATA_WIDTH + 1);

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrc_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   bclk_q;

  logic                   bclk_s;
  logic                   lrc_s;
  logic                   dat_s;
  logic                   rise;

  logic                   primed_q,     primed_d;
  logic                   lrc_last_q,   lrc_last_d;
  logic [CNT_W-1:0]       bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-2:0]  shift_q,      shift_d;
  logic [DATA_WIDTH-1:0]  left_hold_q,  left_hold_d;
  logic                   left_ok_q,    left_ok_d;
  logic [DATA_WIDTH-1:0]  data_left_q,  data_left_d;
  logic [DATA_WIDTH-1:0]  data_right_q, data_right_d;
  logic                   valid_q,      valid_d;
  logic                   error_q,      error_d;

  logic                   cnt_active;
  logic [DATA_WIDTH-1:0]  word;

  // Same depth on all three lines keeps data and LRC aligned with the detected rise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      dat_sync_q  <= '0;
      bclk_q      <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        bclk_sync_q[i] <= bclk_sync_q[i-1];
        lrc_sync_q[i]  <= lrc_sync_q[i-1];
        dat_sync_q[i]  <= dat_sync_q[i-1];
      end
      bclk_sync_q[0] <= bclk;
      lrc_sync_q[0]  <= adclrc;
      dat_sync_q[0]  <= adcdat;
      bclk_q         <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign bclk_s     = bclk_sync_q[SYNC_STAGES-1];
  assign lrc_s      = lrc_sync_q[SYNC_STAGES-1];
  assign dat_s      = dat_sync_q[SYNC_STAGES-1];
  assign rise       = bclk_s & ~bclk_q;
  assign cnt_active = (bit_cnt_q >= CNT_FIRST) && (bit_cnt_q <= CNT_LAST);
  assign word       = {shift_q, dat_s};

  always_comb begin
    primed_d     = primed_q;
    lrc_last_d   = lrc_last_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    left_ok_d    = left_ok_q;
    data_left_d  = data_left_q;
    data_right_d = data_right_q;
    valid_d      = 1'b0;
    error_d      = 1'b0;

    if (rise) begin
      lrc_last_d = lrc_s;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (lrc_s != lrc_last_q) begin
        // An LRC edge while a word is still being collected truncates it.
        if (cnt_active) begin
          error_d   = 1'b1;
          left_ok_d = 1'b0;
          shift_d   = '0;
        end
        bit_cnt_d = CNT_FIRST;
      end else if (cnt_active) begin
        shift_d   = word[DATA_WIDTH-2:0];
        bit_cnt_d = bit_cnt_q + CNT_FIRST;
        if (bit_cnt_q == CNT_LAST) begin
          if (!lrc_s) begin
            left_hold_d = word;
            left_ok_d   = 1'b1;
          end else if (left_ok_q) begin
            data_left_d  = left_hold_q;
            data_right_d = word;
            valid_d      = 1'b1;
            left_ok_d    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      primed_q     <= 1'b0;
      lrc_last_q   <= 1'b0;
      bit_cnt_q    <= CNT_IDLE;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_ok_q    <= 1'b0;
      data_left_q  <= '0;
      data_right_q <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      primed_q     <= primed_d;
      lrc_last_q   <= lrc_last_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      left_ok_q    <= left_ok_d;
      data_left_q  <= data_left_d;
      data_right_q <= data_right_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  assign data_left    = data_left_q;
  assign data_right   = data_right_q;
  assign sample_valid = valid_q;
  assign frame_error  = error_q;

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Self-checking bench for audio_adc_receiver: drives codec-style serial frames
// and compares received stereo samples against per-test expected queues.
module tb_audio_adc_receiver;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        bclk = 1'b1;
  logic        adclrc = 1'b0;
  logic        adcdat = 1'b0;
  logic [23:0] data_left;
  logic [23:0] data_right;
  logic        sample_valid;
  logic        frame_error;

  int total = 0;
  int bad = 0;

  audio_adc_receiver #(.DATA_WIDTH(24), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .bclk        (bclk),
    .adclrc      (adclrc),
    .adcdat      (adcdat),
    .data_left   (data_left),
    .data_right  (data_right),
    .sample_valid(sample_valid),
    .frame_error (frame_error)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: records every strobe and tallies protocol anomalies.
  logic [23:0] obs_l[$];
  logic [23:0] obs_r[$];
  int          err_cnt = 0;
  int          wide_valid = 0;
  int          coincide = 0;
  int          hold_viol = 0;
  logic        prev_valid = 1'b0;
  logic [23:0] prev_l = '0;
  logic [23:0] prev_r = '0;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (sample_valid) begin
        obs_l.push_back(data_left);
        obs_r.push_back(data_right);
        if (prev_valid) wide_valid++;
      end
      if (frame_error) err_cnt++;
      if (sample_valid && frame_error) coincide++;
      if (!sample_valid && (data_left !== prev_l || data_right !== prev_r)) hold_viol++;
    end
    prev_valid = sample_valid;
    prev_l     = data_left;
    prev_r     = data_right;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  // One BCLK period: LRC/data change around the falling edge, sampled at the rise.
  task automatic slot(input logic lrc, input logic d, input int half, input bit jit);
    int lo, hi, sk;
    lo = half;
    hi = half;
    sk = 0;
    if (jit) begin
      lo = half - 1 + int'($urandom_range(0, 2));
      hi = half - 1 + int'($urandom_range(0, 2));
      sk = int'($urandom_range(0, 2)) - 1;
    end
    if (sk < 0) begin
      adclrc = lrc; adcdat = d; wait_cyc(1); bclk = 1'b0; wait_cyc(lo);
    end else if (sk == 0) begin
      adclrc = lrc; adcdat = d; bclk = 1'b0; wait_cyc(lo);
    end else begin
      bclk = 1'b0; wait_cyc(1); adclrc = lrc; adcdat = d; wait_cyc(lo - 1);
    end
    bclk = 1'b1;
    wait_cyc(hi);
  endtask

  task automatic send_chan(input logic lrc, input logic [23:0] w, input int ndata,
                           input int nextra, input int half, input bit jit);
    slot(lrc, 1'($urandom), half, jit);
    for (int i = 0; i < ndata; i++) slot(lrc, w[23-i], half, jit);
    for (int i = 0; i < nextra; i++) slot(lrc, 1'($urandom), half, jit);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    wait_cyc(4);
    total++; if (data_left !== 24'h0) begin bad++; $display("FAIL reset_left: got %h want 000000", data_left); end
    total++; if (data_right !== 24'h0) begin bad++; $display("FAIL reset_right: got %h want 000000", data_right); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", frame_error); end
    sys_rst_n = 1'b1;
    wait_cyc(4);
    $display("test_reset: outputs zero after reset");
  endtask

  task automatic test_frames;
    logic [23:0] el[$];
    logic [23:0] er[$];
    int e0;
    obs_l.delete(); obs_r.delete();
    e0 = err_cnt;
    // Partial left then a full right with no preceding left: must be suppressed.
    for (int i = 0; i < 7; i++) slot(1'b0, 1'($urandom), 10, 1'b0);
    send_chan(1'b1, 24'($urandom), 24, 0, 10, 1'b0);
    el = '{24'hA5A5A5, 24'h000001, 24'hFFFFFF};
    er = '{24'h5A5A5A, 24'h800000, 24'h000000};
    for (int f = 0; f < 3; f++) begin
      send_chan(1'b0, el[f], 24, 0, 10, 1'b0);
      send_chan(1'b1, er[f], 24, 0, 10, 1'b0);
    end
    wait_cyc(20);
    total++;
    if (obs_l.size() !== el.size()) begin bad++; $display("FAIL frames_count: got %0d want %0d", obs_l.size(), el.size()); end
    for (int i = 0; i < el.size() && i < obs_l.size(); i++) begin
      total++;
      if (obs_l[i] !== el[i] || obs_r[i] !== er[i]) begin
        bad++; $display("FAIL frames_data[%0d]: got %h/%h want %h/%h", i, obs_l[i], obs_r[i], el[i], er[i]);
      end
      $display("frame %0d: L=%h R=%h", i, obs_l[i], obs_r[i]);
    end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL frames_err: got %0d want 0", err_cnt - e0); end
    total++; if (wide_valid !== 0) begin bad++; $display("FAIL valid_width: got %0d wide pulses want 0", wide_valid); end
  endtask

  task automatic test_truncated;
    int e0;
    obs_l.delete(); obs_r.delete();
    e0 = err_cnt;
    send_chan(1'b0, 24'($urandom), 10, 0, 10, 1'b0);
    send_chan(1'b1, 24'($urandom), 24, 0, 10, 1'b0);
    send_chan(1'b0, 24'h123456, 24, 0, 10, 1'b0);
    send_chan(1'b1, 24'h654321, 24, 0, 10, 1'b0);
    wait_cyc(20);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL trunc_err: got %0d want 1", err_cnt - e0); end
    total++; if (obs_l.size() !== 1) begin bad++; $display("FAIL trunc_count: got %0d want 1", obs_l.size()); end
    if (obs_l.size() > 0) begin
      total++;
      if (obs_l[0] !== 24'h123456 || obs_r[0] !== 24'h654321) begin
        bad++; $display("FAIL trunc_data: got %h/%h want 123456/654321", obs_l[0], obs_r[0]);
      end
      $display("truncated: next frame L=%h R=%h", obs_l[0], obs_r[0]);
    end
    total++; if (coincide !== 0) begin bad++; $display("FAIL trunc_coincide: got %0d want 0", coincide); end
  endtask

  task automatic test_long;
    int e0;
    obs_l.delete(); obs_r.delete();
    e0 = err_cnt;
    send_chan(1'b0, 24'hC0FFEE, 24, 7, 10, 1'b0);
    send_chan(1'b1, 24'hBEEF01, 24, 7, 10, 1'b0);
    wait_cyc(20);
    total++; if (obs_l.size() !== 1) begin bad++; $display("FAIL long_count: got %0d want 1", obs_l.size()); end
    if (obs_l.size() > 0) begin
      total++;
      if (obs_l[0] !== 24'hC0FFEE || obs_r[0] !== 24'hBEEF01) begin
        bad++; $display("FAIL long_data: got %h/%h want c0ffee/beef01", obs_l[0], obs_r[0]);
      end
      $display("long: L=%h R=%h", obs_l[0], obs_r[0]);
    end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL long_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    logic [23:0] el[$];
    logic [23:0] er[$];
    logic [23:0] rw;
    int e0;
    obs_l.delete(); obs_r.delete();
    e0 = err_cnt;
    rw = 24'($urandom);
    send_chan(1'b0, 24'($urandom), 24, 0, 10, 1'b0);
    slot(1'b1, 1'($urandom), 10, 1'b0);
    for (int i = 0; i < 12; i++) slot(1'b1, rw[23-i], 10, 1'b0);
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    #1;
    total++; if (data_left !== 24'h0 || data_right !== 24'h0) begin bad++; $display("FAIL midreset_data: got %h/%h want 000000/000000", data_left, data_right); end
    total++; if (sample_valid !== 1'b0 || frame_error !== 1'b0) begin bad++; $display("FAIL midreset_flags: got %b/%b want 0/0", sample_valid, frame_error); end
    repeat (5) @(posedge sys_clk);
    #3;
    total++; if (data_left !== 24'h0 || data_right !== 24'h0) begin bad++; $display("FAIL midreset_hold: got %h/%h want 000000/000000", data_left, data_right); end
    sys_rst_n = 1'b1;
    wait_cyc(1);
    for (int i = 12; i < 24; i++) slot(1'b1, rw[23-i], 10, 1'b0);
    for (int f = 0; f < 2; f++) begin
      el.push_back(24'($urandom));
      er.push_back(24'($urandom));
      send_chan(1'b0, el[f], 24, 0, 10, 1'b0);
      send_chan(1'b1, er[f], 24, 0, 10, 1'b0);
    end
    wait_cyc(20);
    total++; if (obs_l.size() !== 2) begin bad++; $display("FAIL midreset_count: got %0d want 2", obs_l.size()); end
    for (int i = 0; i < 2 && i < obs_l.size(); i++) begin
      total++;
      if (obs_l[i] !== el[i] || obs_r[i] !== er[i]) begin
        bad++; $display("FAIL midreset_data[%0d]: got %h/%h want %h/%h", i, obs_l[i], obs_r[i], el[i], er[i]);
      end
      $display("after reset frame %0d: L=%h R=%h", i, obs_l[i], obs_r[i]);
    end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL midreset_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_jitter;
    logic [23:0] el[$];
    logic [23:0] er[$];
    int e0, nbad;
    obs_l.delete(); obs_r.delete();
    e0 = err_cnt;
    nbad = 0;
    for (int f = 0; f < 100; f++) begin
      el.push_back(24'($urandom));
      er.push_back(24'($urandom));
      send_chan(1'b0, el[f], 24, 0, 4, 1'b1);
      send_chan(1'b1, er[f], 24, 0, 4, 1'b1);
    end
    wait_cyc(20);
    total++; if (obs_l.size() !== 100) begin bad++; $display("FAIL jitter_count: got %0d want 100", obs_l.size()); end
    for (int i = 0; i < 100 && i < obs_l.size(); i++) begin
      total++;
      if (obs_l[i] !== el[i] || obs_r[i] !== er[i]) begin
        bad++; nbad++;
        $display("FAIL jitter_data[%0d]: got %h/%h want %h/%h", i, obs_l[i], obs_r[i], el[i], er[i]);
      end
    end
    $display("jitter: %0d frames received, %0d wrong", obs_l.size(), nbad);
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL jitter_err: got %0d want 0", err_cnt - e0); end
    total++; if (hold_viol !== 0) begin bad++; $display("FAIL output_hold: got %0d changes without strobe want 0", hold_viol); end
    total++; if (wide_valid !== 0) begin bad++; $display("FAIL valid_width_final: got %0d want 0", wide_valid); end
    total++; if (coincide !== 0) begin bad++; $display("FAIL coincide_final: got %0d want 0", coincide); end
  endtask

  initial begin
    @(posedge sys_clk); #2;
    test_reset;
    test_frames;
    test_truncated;
    test_long;
    test_reset_mid;
    test_jitter;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
